// File: rtl/pcs_ctrl_pkg.sv
// Shared types and defaults for the PCS transmit/receive control blocks.
package pcs_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_XCVR = 2'd0,
    SCR_INIT  = 2'd1,
    RUN       = 2'd2
  } tx_seq_state_t;

  localparam int PCS_PAUSE_PERIOD = 33;
  localparam int PCS_INIT_WAIT    = 16;
  localparam int GEARBOX_SEQ_W    = 6;

endpackage

// File: rtl/gearbox_seq_counter.sv
// Gearbox sequence counter: walks 0..PAUSE_PERIOD-1 while enabled and flags
// the last index of each sequence as a registered pause. Shared with RX.
module gearbox_seq_counter
  import pcs_ctrl_pkg::*;
#(
  parameter int PAUSE_PERIOD = PCS_PAUSE_PERIOD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  output logic [GEARBOX_SEQ_W-1:0] seq,
  output logic                     pause
);

  localparam logic [GEARBOX_SEQ_W-1:0] SEQ_LAST = GEARBOX_SEQ_W'(PAUSE_PERIOD - 1);

  logic [GEARBOX_SEQ_W-1:0] seq_q, seq_d;
  logic                     pause_q, pause_d;

  // Next index with wrap; pause is the compare of the next index so it lines
  // up with the index it describes.
  always_comb begin
    seq_d   = seq_q;
    pause_d = pause_q;
    if (clear) begin
      seq_d   = '0;
      pause_d = 1'b0;
    end else if (enable) begin
      seq_d   = (seq_q == SEQ_LAST) ? '0 : seq_q + GEARBOX_SEQ_W'(1);
      pause_d = (seq_d == SEQ_LAST);
    end
  end

  // Sequence and pause registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q   <= '0;
      pause_q <= 1'b0;
    end else begin
      seq_q   <= seq_d;
      pause_q <= pause_d;
    end
  end

  assign seq   = seq_q;
  assign pause = pause_q;

endmodule

// File: rtl/tx_pcs_sequencer.sv
// 10G PCS transmit sequencer: start-up after transceiver ready, scrambler
// init window, then periodic gearbox pause and MAC ready in run mode.
// Optional pause statistics counter: define TX_PCS_PAUSE_STATS_EN.
//
// state     | meaning
// WAIT_XCVR | waiting for transceiver ready with no fault
// SCR_INIT  | encoder emitting idles, scrambler held in init for INIT_WAIT cycles
// RUN       | datapath live, gearbox pause once per PAUSE_PERIOD cycles
module tx_pcs_sequencer
  import pcs_ctrl_pkg::*;
#(
  parameter int PAUSE_PERIOD = PCS_PAUSE_PERIOD,
  parameter int INIT_WAIT    = PCS_INIT_WAIT
) (
  input  logic                     i_txc,
  input  logic                     i_reset,
  input  logic                     i_init_done,
  input  logic                     i_xcvr_fault,
  output logic                     o_encoder_init_done,
  output logic                     o_scrambler_init_done,
  output logic                     o_tx_pause,
  output logic                     o_mac_ready,
  output logic [GEARBOX_SEQ_W-1:0] o_gearbox_seq,
  output logic [1:0]               o_state,
  output logic [31:0]              o_pause_count
);

  localparam logic [7:0] INIT_LAST = 8'(INIT_WAIT - 1);

  tx_seq_state_t state_q, state_d;
  logic [7:0]    init_cnt_q, init_cnt_d;
  logic          enc_q, enc_d;
  logic          scr_q, scr_d;
  logic          link_ok;
  logic          seq_en;
  logic          pause;

  assign link_ok = i_init_done & ~i_xcvr_fault;

  // Next-state and registered-output decode; a lost link wins over everything.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    enc_d      = enc_q;
    scr_d      = scr_q;
    if (!link_ok) begin
      state_d    = WAIT_XCVR;
      init_cnt_d = '0;
      enc_d      = 1'b0;
      scr_d      = 1'b0;
    end else begin
      case (state_q)
        WAIT_XCVR: begin
          state_d    = SCR_INIT;
          enc_d      = 1'b1;
          init_cnt_d = '0;
        end
        SCR_INIT: begin
          init_cnt_d = init_cnt_q + 8'd1;
          if (init_cnt_q == INIT_LAST) begin
            state_d = RUN;
            scr_d   = 1'b1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d    = WAIT_XCVR;
          init_cnt_d = '0;
          enc_d      = 1'b0;
          scr_d      = 1'b0;
        end
      endcase
    end
  end

  // FSM state, init counter and init-done flags.
  always_ff @(posedge i_txc or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_XCVR;
      init_cnt_q <= '0;
      enc_q      <= 1'b0;
      scr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      enc_q      <= enc_d;
      scr_q      <= scr_d;
    end
  end

  // Sequence only advances while staying in RUN; entering or leaving RUN
  // restarts it at zero.
  assign seq_en = (state_q == RUN) && (state_d == RUN);

  gearbox_seq_counter #(
    .PAUSE_PERIOD(PAUSE_PERIOD)
  ) u_seq (
    .clk   (i_txc),
    .reset (i_reset),
    .enable(seq_en),
    .clear (~seq_en),
    .seq   (o_gearbox_seq),
    .pause (pause)
  );

  assign o_encoder_init_done   = enc_q;
  assign o_scrambler_init_done = scr_q;
  assign o_tx_pause            = pause;
  assign o_state               = state_q;
  assign o_mac_ready           = (state_q == RUN) & ~pause;

`ifdef TX_PCS_PAUSE_STATS_EN
  logic [31:0] pause_cnt_q;

  // Counts pause cycles; survives aborts, cleared only by reset.
  always_ff @(posedge i_txc or posedge i_reset) begin
    if (i_reset) begin
      pause_cnt_q <= '0;
    end else if (pause) begin
      pause_cnt_q <= pause_cnt_q + 32'd1;
    end
  end

  assign o_pause_count = pause_cnt_q;
`else
  assign o_pause_count = '0;
`endif

endmodule

// File: tb/tb_tx_pcs_sequencer.sv
// Bench for tx_pcs_sequencer: two instances (33/16 and 2/1) checked every
// cycle against a behavioural model built from RUN-cycle arithmetic.
module tb_tx_pcs_sequencer;

  localparam int PA = 33;
  localparam int WA = 16;
  localparam int PB = 2;
  localparam int WB = 1;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_init, a_fault;
  logic        a_enc, a_scr, a_pause, a_mac;
  logic [5:0]  a_seq;
  logic [1:0]  a_state;
  logic [31:0] a_pcnt;

  logic        b_reset, b_init, b_fault;
  logic        b_enc, b_scr, b_pause, b_mac;
  logic [5:0]  b_seq;
  logic [1:0]  b_state;
  logic [31:0] b_pcnt;

  tx_pcs_sequencer #(.PAUSE_PERIOD(PA), .INIT_WAIT(WA)) dut_a (
    .i_txc(clk), .i_reset(a_reset), .i_init_done(a_init), .i_xcvr_fault(a_fault),
    .o_encoder_init_done(a_enc), .o_scrambler_init_done(a_scr), .o_tx_pause(a_pause),
    .o_mac_ready(a_mac), .o_gearbox_seq(a_seq), .o_state(a_state), .o_pause_count(a_pcnt)
  );

  tx_pcs_sequencer #(.PAUSE_PERIOD(PB), .INIT_WAIT(WB)) dut_b (
    .i_txc(clk), .i_reset(b_reset), .i_init_done(b_init), .i_xcvr_fault(b_fault),
    .o_encoder_init_done(b_enc), .o_scrambler_init_done(b_scr), .o_tx_pause(b_pause),
    .o_mac_ready(b_mac), .o_gearbox_seq(b_seq), .o_state(b_state), .o_pause_count(b_pcnt)
  );

  logic [43:0] obs_a, obs_b;
  assign obs_a = {a_state, a_enc, a_scr, a_pause, a_mac, a_seq, a_pcnt};
  assign obs_b = {b_state, b_enc, b_scr, b_pause, b_mac, b_seq, b_pcnt};

  // phase: 0 waiting, 1 initialising, 2 running.
  // init_n: completed init cycles; run_n: 1-based index of the current RUN cycle.
  typedef struct {
    int          phase;
    int          init_n;
    int          run_n;
    int unsigned pcount;
    int          p;
    int          w;
  } model_t;

  model_t ma, mb;
  int total = 0;
  int bad   = 0;

  function automatic model_t m_reset(int p, int w);
    model_t m;
    m.phase = 0; m.init_n = 0; m.run_n = 0; m.pcount = 0; m.p = p; m.w = w;
    return m;
  endfunction

  function automatic bit m_pause(model_t m);
    return (m.phase == 2) && ((m.run_n % m.p) == 0);
  endfunction

  function automatic model_t m_step(model_t m, bit ok);
    model_t n;
    n = m;
    if (m_pause(m)) n.pcount = m.pcount + 1;
    if (!ok) begin
      n.phase = 0; n.init_n = 0; n.run_n = 0;
    end else if (m.phase == 0) begin
      n.phase = 1; n.init_n = 0;
    end else if (m.phase == 1) begin
      n.init_n = m.init_n + 1;
      if (n.init_n == m.w) begin
        n.phase = 2; n.run_n = 1;
      end
    end else begin
      n.run_n = m.run_n + 1;
    end
    return n;
  endfunction

  function automatic logic [43:0] exp_vec(model_t m);
    logic        pz;
    logic [5:0]  sq;
    logic [31:0] pc;
    pz = m_pause(m);
    sq = (m.phase == 2) ? 6'((m.run_n - 1) % m.p) : 6'd0;
`ifdef TX_PCS_PAUSE_STATS_EN
    pc = m.pcount;
`else
    pc = 32'd0;
`endif
    return {2'(m.phase), (m.phase != 0), (m.phase == 2), pz, (m.phase == 2) && !pz, sq, pc};
  endfunction

  // One clock edge for both instances; models follow the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (a_reset) ma = m_reset(PA, WA);
    else         ma = m_step(ma, a_init && !a_fault);
    if (b_reset) mb = m_reset(PB, WB);
    else         mb = m_step(mb, b_init && !b_fault);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    a_init = 1'b0; a_fault = 1'b0; b_init = 1'b0; b_fault = 1'b0;
    ma = m_reset(PA, WA); mb = m_reset(PB, WB);
    tick();
    a_init = 1'b1; b_init = 1'b1;
    tick();
    total++;
    if (obs_a !== 44'd0) begin
      bad++; $display("FAIL reset_a got=%h exp=%h", obs_a, 44'd0);
    end
    total++;
    if (obs_b !== 44'd0) begin
      bad++; $display("FAIL reset_b got=%h exp=%h", obs_b, 44'd0);
    end
    a_init = 1'b0; b_init = 1'b0;
    a_reset = 1'b0; b_reset = 1'b0;
  endtask

  task automatic test_startup();
    int enc_t, scr_t;
    enc_t = -1; scr_t = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs_a !== exp_vec(ma)) begin
        bad++; $display("FAIL startup_idle cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(ma));
      end
    end
    a_init = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (a_enc && enc_t < 0) enc_t = i;
      if (a_scr && scr_t < 0) scr_t = i;
      total++;
      if (obs_a !== exp_vec(ma)) begin
        bad++; $display("FAIL startup cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(ma));
      end
    end
    total++;
    if (enc_t !== 0) begin
      bad++; $display("FAIL enc_rise_edge got=%0d exp=0", enc_t);
    end
    total++;
    if (scr_t - enc_t !== 16) begin
      bad++; $display("FAIL scr_delay got=%0d exp=16", scr_t - enc_t);
    end
  endtask

  task automatic test_run_pause();
    int pq[$];
    int exp_pc;
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) tick();
      if (a_pause) pq.push_back(k);
      total++;
      if (obs_a !== exp_vec(ma)) begin
        bad++; $display("FAIL run k=%0d got=%h exp=%h", k, obs_a, exp_vec(ma));
      end
      if (k == 34) begin
        total++;
        if (a_seq !== 6'd0) begin
          bad++; $display("FAIL seq_wrap got=%0d exp=0", a_seq);
        end
      end
    end
    total++;
    if (pq.size() != 3 || pq[0] != 33 || pq[1] != 66 || pq[2] != 99) begin
      bad++; $display("FAIL pause_cycles got_count=%0d exp=3 (33,66,99)", pq.size());
    end
`ifdef TX_PCS_PAUSE_STATS_EN
    exp_pc = 3;
`else
    exp_pc = 0;
`endif
    total++;
    if (a_pcnt !== 32'(exp_pc)) begin
      bad++; $display("FAIL pause_count got=%0d exp=%0d", a_pcnt, exp_pc);
    end
  endtask

  task automatic test_fault_abort();
    int ent;
    ent = -1;
    for (int i = 0; i < 40 && (ma.run_n % PA) != 7; i++) tick();
    a_fault = 1'b1;
    tick();
    a_fault = 1'b0;
    total++;
    if (obs_a[43:32] !== 12'd0) begin
      bad++; $display("FAIL fault_clear got=%h exp=0", obs_a[43:32]);
    end
    total++;
    if (obs_a !== exp_vec(ma)) begin
      bad++; $display("FAIL fault_model got=%h exp=%h", obs_a, exp_vec(ma));
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (obs_a !== exp_vec(ma)) begin
        bad++; $display("FAIL fault_reentry cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(ma));
      end
      if (a_state == 2'd2 && ent < 0) begin
        ent = i;
        total++;
        if (a_seq !== 6'd0) begin
          bad++; $display("FAIL reentry_seq got=%0d exp=0", a_seq);
        end
      end
    end
    total++;
    if (ent !== 16) begin
      bad++; $display("FAIL reentry_window got=%0d exp=16", ent);
    end
  endtask

  task automatic test_init_abort();
    logic scr_seen;
    scr_seen = 1'b0;
    a_init = 1'b0;
    tick();
    total++;
    if (obs_a !== exp_vec(ma)) begin
      bad++; $display("FAIL drop_in_run got=%h exp=%h", obs_a, exp_vec(ma));
    end
    a_init = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      scr_seen = scr_seen | a_scr;
      total++;
      if (obs_a !== exp_vec(ma)) begin
        bad++; $display("FAIL init_window cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(ma));
      end
    end
    a_init = 1'b0;
    tick();
    scr_seen = scr_seen | a_scr;
    total++;
    if (a_state !== 2'd0 || scr_seen !== 1'b0) begin
      bad++; $display("FAIL init_abort state=%0d scr_seen=%0b exp state=0 scr_seen=0", a_state, scr_seen);
    end
    total++;
    if (obs_a !== exp_vec(ma)) begin
      bad++; $display("FAIL init_abort_model got=%h exp=%h", obs_a, exp_vec(ma));
    end
  endtask

  task automatic test_async_reset();
    a_init = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      total++;
      if (obs_a !== exp_vec(ma)) begin
        bad++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(ma));
      end
    end
    #2;
    a_reset = 1'b1;
    ma = m_reset(PA, WA);
    #1;
    total++;
    if (obs_a !== 44'd0) begin
      bad++; $display("FAIL async_reset got=%h exp=0", obs_a);
    end
    tick();
    a_reset = 1'b0;
    tick();
    total++;
    if (obs_a !== exp_vec(ma)) begin
      bad++; $display("FAIL post_reset got=%h exp=%h", obs_a, exp_vec(ma));
    end
  endtask

  task automatic test_short_period();
    logic prev;
    int   npause;
    prev = b_pause;
    npause = 0;
    b_init = 1'b1; b_fault = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (b_pause) npause++;
      total++;
      if (obs_b !== exp_vec(mb)) begin
        bad++; $display("FAIL short cyc=%0d got=%h exp=%h", i, obs_b, exp_vec(mb));
      end
      total++;
      if (prev && b_pause) begin
        bad++; $display("FAIL short_consecutive cyc=%0d got=1 exp=0", i);
      end
      prev = b_pause;
    end
    total++;
    if (npause !== mb.run_n / 2) begin
      bad++; $display("FAIL short_pause_count got=%0d exp=%0d", npause, mb.run_n / 2);
    end
  endtask

  task automatic test_random();
    logic prev_b;
    prev_b = b_pause;
    for (int i = 0; i < 1500; i++) begin
      a_init  = ($urandom_range(0, 59) != 0);
      a_fault = ($urandom_range(0, 89) == 0);
      b_init  = ($urandom_range(0, 9) != 0);
      b_fault = ($urandom_range(0, 14) == 0);
      tick();
      total++;
      if (obs_a !== exp_vec(ma)) begin
        bad++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(ma));
      end
      total++;
      if (obs_b !== exp_vec(mb)) begin
        bad++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", i, obs_b, exp_vec(mb));
      end
      total++;
      if (prev_b && b_pause) begin
        bad++; $display("FAIL rand_b_consecutive cyc=%0d got=1 exp=0", i);
      end
      prev_b = b_pause;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_run_pause();
    test_fault_abort();
    test_init_abort();
    test_async_reset();
    test_short_period();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
